// File: rtl/hazard_stall_unit.sv
// Hazard and stall control for the 5-stage LC-3b pipeline: freezes on cache waits,
// inserts load-use bubbles, squashes on taken branches and counts each event.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       IF_ID_sr1,
  input  logic [2:0]       IF_ID_sr2,
  input  logic             IF_ID_uses_sr1,
  input  logic             IF_ID_uses_sr2,
  input  logic             ID_EX_mem_read,
  input  logic             ID_EX_write,
  input  logic [2:0]       ID_EX_dest,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic             dcache_resp,
  input  logic             branch_taken,
  output logic             pc_load,
  output logic             IF_ID_load,
  output logic             ID_EX_load,
  output logic             EX_MEM_load,
  output logic             MEM_WB_load,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DSTALL   = 2'd1,
    BR_DRAIN = 2'd2
  } state_t;

  state_t state;

  logic dwait, iwait, lu;
  logic freeze, squash, bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign dwait  = (dcache_read | dcache_write) & ~dcache_resp;
  assign iwait  = icache_read & ~icache_resp;
  assign lu     = ID_EX_mem_read & ID_EX_write &
                  ((IF_ID_uses_sr1 & (IF_ID_sr1 == ID_EX_dest)) |
                   (IF_ID_uses_sr2 & (IF_ID_sr2 == ID_EX_dest)));

  // The branch input stays high while frozen, so the squash simply fires once the freeze lifts.
  assign freeze = dwait | (branch_taken & iwait);
  assign squash = ~freeze & branch_taken;
  assign bubble = ~freeze & ~branch_taken & lu;

  always_comb begin
    pc_load      = 1'b1;
    IF_ID_load   = 1'b1;
    ID_EX_load   = 1'b1;
    EX_MEM_load  = 1'b1;
    MEM_WB_load  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (freeze) begin
      pc_load     = 1'b0;
      IF_ID_load  = 1'b0;
      ID_EX_load  = 1'b0;
      EX_MEM_load = 1'b0;
      MEM_WB_load = 1'b0;
    end else if (squash) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (lu) begin
      pc_load     = 1'b0;
      IF_ID_load  = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (iwait) begin
      pc_load     = 1'b0;
      IF_ID_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles, freeze);
      bubble_count <= sat_inc(bubble_count, bubble);
      flush_count  <= sat_inc(flush_count, squash);
      case (state)
        RUN: begin
          if (dwait)                     state <= DSTALL;
          else if (branch_taken & iwait) state <= BR_DRAIN;
        end
        DSTALL: begin
          if (dcache_resp) state <= (branch_taken & iwait) ? BR_DRAIN : RUN;
        end
        BR_DRAIN: begin
          if (icache_resp) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign state_o = state;

endmodule
